// File: rtl/malu_pkg.sv
// malu_pkg: shared constants, state encoding and helpers
// for the 5x5 int8 matrix ALU command sequencer.
package malu_pkg;

    localparam int ROW_W  = 40;
    localparam int N_ROWS = 5;
    localparam int FLAT_W = ROW_W * N_ROWS;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_TRN  = 4'b0100;
    localparam logic [3:0] OP_NEG  = 4'b0101;
    localparam logic [3:0] OP_SMUL = 4'b0110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_CAPTURE,
        S_STORE,
        S_DONE
    } state_e;

    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_TRN) || (op == OP_NEG) || (op == OP_SMUL);
    endfunction

    function automatic logic is_legal(input logic [3:0] op,
                                      input logic [2:0] n);
        return (op >= OP_ADD) && (op <= OP_SMUL) &&
               (n >= 3'd1) && (n <= 3'd5);
    endfunction

    function automatic logic [ROW_W-1:0] row_sel(
        input logic [FLAT_W-1:0] v,
        input logic [2:0]        r
    );
        logic [ROW_W-1:0] row;
        row = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            if (r == 3'(i)) row = v[ROW_W*i +: ROW_W];
        end
        return row;
    endfunction

endpackage

// File: rtl/malu_row_seq.sv
// malu_row_seq: row counter shared by the load and store phases.
// Ports: en_i (phase active), store_i (5-cycle write phase vs
// 6-cycle read phase), issue_o/row_o (access row), cap_o/cap_row_o
// (read data of that row is on mem_rdata now), last_o (final cycle).
module malu_row_seq
    import malu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       store_i,
    output logic       issue_o,
    output logic       cap_o,
    output logic       last_o,
    output logic [2:0] row_o,
    output logic [2:0] cap_row_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [2:0] last_cnt;

    // A read phase needs one extra cycle to catch the last row's data.
    assign last_cnt  = store_i ? 3'(N_ROWS - 1) : 3'(N_ROWS);
    assign issue_o   = en_i && (cnt_q < 3'(N_ROWS));
    assign cap_o     = en_i && !store_i && (cnt_q != 3'd0);
    assign last_o    = en_i && (cnt_q == last_cnt);
    assign row_o     = cnt_q;
    assign cap_row_o = cnt_q - 3'd1;

    always_comb begin
        cnt_d = cnt_q + 3'd1;
        if (!en_i || last_o) cnt_d = 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 3'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/malu_ctrl.sv
// malu_ctrl: command sequencer for the 5x5 int8 matrix ALU.
// Ports: cmd_* host handshake and fields; mem_* row memory
// (read data one cycle after mem_rd_en); alu_* to/from malu;
// busy (not idle), done (1-cycle pulse), err (valid with done).
module malu_ctrl
    import malu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int EXEC_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [2:0]        cmd_n,
    input  logic [8:0]        cmd_f,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [ADDR_W-1:0] cmd_addr_c,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [39:0]       mem_wdata,
    input  logic [39:0]       mem_rdata,
    output logic [199:0]      alu_a_flat,
    output logic [199:0]      alu_b_flat,
    output logic [3:0]        alu_opcode,
    output logic [2:0]        alu_n,
    output logic [8:0]        alu_f,
    input  logic [199:0]      alu_c_flat,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] WAIT_LAST = 8'(EXEC_WAIT - 1);

    state_e              state_q;
    state_e              state_d;
    logic [3:0]          op_q;
    logic [ADDR_W-1:0]   addr_a_q;
    logic [ADDR_W-1:0]   addr_b_q;
    logic [ADDR_W-1:0]   addr_c_q;
    logic                err_q;
    logic [2:0]          n_q;
    logic [8:0]          f_q;
    logic [7:0]          wait_q;
    logic [FLAT_W-1:0]   a_q;
    logic [FLAT_W-1:0]   b_q;
    logic [FLAT_W-1:0]   c_q;

    logic       accept;
    logic       cmd_legal;
    logic       seq_en;
    logic       seq_store;
    logic       seq_issue;
    logic       seq_cap;
    logic       seq_last;
    logic [2:0] seq_row;
    logic [2:0] seq_cap_row;

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_legal = is_legal(cmd_opcode, cmd_n);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;

    assign seq_store = (state_q == S_STORE);
    assign seq_en    = (state_q == S_LOAD_A) ||
                       (state_q == S_LOAD_B) || seq_store;

    assign alu_a_flat = a_q;
    assign alu_b_flat = b_q;
    assign alu_n      = n_q;
    assign alu_f      = f_q;

    malu_row_seq u_row_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (seq_en),
        .store_i   (seq_store),
        .issue_o   (seq_issue),
        .cap_o     (seq_cap),
        .last_o    (seq_last),
        .row_o     (seq_row),
        .cap_row_o (seq_cap_row)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = cmd_legal ? S_LOAD_A : S_DONE;
            end
            S_LOAD_A: begin
                if (seq_last) state_d = is_unary(op_q) ? S_EXEC : S_LOAD_B;
            end
            S_LOAD_B:  if (seq_last) state_d = S_EXEC;
            S_EXEC:    if (wait_q == WAIT_LAST) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_STORE;
            S_STORE:   if (seq_last) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Opcode returns to 0 outside EXEC/CAPTURE so malu sees a fresh
    // edge even for repeated identical commands.
    always_comb begin
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        alu_opcode = OP_NOP;
        unique case (state_q)
            S_LOAD_A: begin
                mem_rd_en = seq_issue;
                if (seq_issue) mem_addr = addr_a_q + ADDR_W'(seq_row);
            end
            S_LOAD_B: begin
                mem_rd_en = seq_issue;
                if (seq_issue) mem_addr = addr_b_q + ADDR_W'(seq_row);
            end
            S_EXEC, S_CAPTURE: begin
                alu_opcode = op_q;
            end
            S_STORE: begin
                mem_wr_en = seq_issue;
                mem_addr  = addr_c_q + ADDR_W'(seq_row);
                mem_wdata = row_sel(c_q, seq_row);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            err_q    <= 1'b0;
            n_q      <= '0;
            f_q      <= '0;
            wait_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= cmd_opcode;
                addr_a_q <= cmd_addr_a;
                addr_b_q <= cmd_addr_b;
                addr_c_q <= cmd_addr_c;
                err_q    <= !cmd_legal;
                // Rejected commands leave the ALU-facing fields alone.
                if (cmd_legal) begin
                    n_q <= cmd_n;
                    f_q <= cmd_f;
                end
            end
            wait_q <= (state_q == S_EXEC) ? wait_q + 8'd1 : 8'd0;
            for (int r = 0; r < N_ROWS; r++) begin
                if (seq_cap && seq_cap_row == 3'(r)) begin
                    if (state_q == S_LOAD_A) a_q[ROW_W*r +: ROW_W] <= mem_rdata;
                    else                     b_q[ROW_W*r +: ROW_W] <= mem_rdata;
                end
            end
            if (state_q == S_CAPTURE) c_q <= alu_c_flat;
        end
    end

endmodule
